verinject_lockstep_checker: RTL
===============================

# verinject_lockstep_checker

Synthesizable lockstep comparator that checks a golden (`top`) design against its fault-injected twin (`top__injected`) across several output channels in parallel. Each cycle it compares per-channel words, keeps sticky and counted mismatch status, captures the cycle of first divergence, and pushes mismatch events into a FIFO log drained by a ready/valid consumer. It sits beside `verinject_file_tester` and `verinject_sim_monitor` and replaces ad-hoc `$display` comparison in benches, so results are observable in emulation and FPGA runs.

## Interface
- `CHANNELS`, 2, number of compared channels (≥1)
- `WIDTH`, 32, bits per channel (≥1)
- `LOG_DEPTH`, 4, log FIFO holds 2**LOG_DEPTH entries
- `COUNT_WIDTH`, 16, width of the saturating mismatch counter
- `STOP_ON_FIRST`, 0, 1 = freeze logging and counting after the first mismatch until `clear`

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `enable`  in  1  compare this cycle
- `clear`  in  1  synchronous clear of status, counter and log
- `cycle_number`  in  48  current cycle from injector
- `real_data`  in  CHANNELS*WIDTH  golden outputs, channel i at [i*WIDTH +: WIDTH]
- `inj_data`  in  CHANNELS*WIDTH  injected outputs, same packing
- `channel_mask`  in  CHANNELS  1 = channel ignored
- `mismatch_now`  out  CHANNELS  registered per-channel mismatch of last compare
- `mismatch_sticky`  out  CHANNELS  OR of all mismatches since reset/clear
- `first_valid`  out  1  a first divergence has been captured
- `first_cycle`  out  48  `cycle_number` of first divergence
- `mismatch_count`  out  COUNT_WIDTH  compare cycles with ≥1 mismatching channel, saturating
- `log_valid`  out  1  log head valid
- `log_ready`  in  1  consumer accepts head
- `log_cycle`  out  48  head: cycle of event
- `log_channels`  out  CHANNELS  head: bitmap of mismatching channels
- `log_xor`  out  WIDTH  head: real^inj of lowest-index mismatching channel
- `log_overflow`  out  1  sticky: an event was dropped because log was full

## Operation
- Per channel: `hit[i] = enable & ~channel_mask[i] & (real_i != inj_i)`; `any = |hit`.
- States: ARMED (reset state), DIVERGED (after first `any`), FROZEN (only when STOP_ON_FIRST=1, entered with the first `any`).
- ARMED, `any` -> capture `first_cycle`, set `first_valid`, go DIVERGED (or FROZEN).
- ARMED/DIVERGED, `any`: `mismatch_sticky |= hit`, `mismatch_count` +1 unless at all-ones, push log entry {cycle_number, hit, xor of lowest set hit}.
- FROZEN: `mismatch_now` still updates; sticky, counter, log pushes, `first_*` do not change.
- `mismatch_now <= hit` every cycle (0 when `enable` low).
- FIFO: first-word-fall-through; pop on `log_valid & log_ready`. Push when full and no pop in the same cycle -> entry dropped, `log_overflow` set. Push+pop while full -> both performed, no overflow. Pop when empty ignored.
- `clear`: empties FIFO, zeros sticky, counter, `first_*`, `log_overflow`, `mismatch_now`; state -> ARMED. `clear` wins over a same-cycle compare (that compare is not recorded).
- `reset` asserted mid-operation: all state cleared immediately, identical to reset values.

## Timing
- Reset values: all outputs 0; state ARMED; FIFO empty.
- Inputs sampled on rising edge; `mismatch_now`, `mismatch_sticky`, `mismatch_count`, `first_*` reflect that sample one cycle later.
- Pushed entry visible on `log_valid`/`log_*` the cycle after the push edge (FIFO empty case).
- After a pop, next entry presented the following cycle; back-to-back pops at one per cycle.
- `log_*` data stable while `log_valid & ~log_ready`.

## Test plan
- Equal data on both channels for 100 cycles -> all outputs stay 0, `log_valid` 0.
- Ch1 differs at cycle 37 with xor 0x00000100 -> next cycle `mismatch_now`=2'b10, `first_cycle`=37, `mismatch_count`=1, log head {37, 2'b10, 0x00000100}.
- Both channels differ, ch0 xor 0x1, ch1 xor 0x8, one cycle, `channel_mask`=2'b01 -> log {cycle, 2'b10, 0x8}; count 1; ch0 sticky stays 0.
- `log_ready`=0, 20 mismatch cycles, LOG_DEPTH=4 -> 16 entries held, `log_overflow`=1, count 20; then ready high -> 16 pops in consecutive cycles, oldest first.
- STOP_ON_FIRST=1, mismatches at cycles 10 and 12 -> count 1, one log entry (cycle 10), `mismatch_now` pulses both times; `clear` then mismatch at 20 -> `first_cycle`=20.
- Mismatch coincident with `clear` -> nothing recorded; `reset` pulsed with 5 entries queued -> all outputs 0 immediately.

Source files
------------

// File: rtl/verinject_lockstep_checker.sv
// rtl/verinject_lockstep_checker.sv - lockstep comparator of golden vs fault-injected outputs with event log
module verinject_lockstep_checker #(
  parameter int CHANNELS      = 2,
  parameter int WIDTH         = 32,
  parameter int LOG_DEPTH     = 4,
  parameter int COUNT_WIDTH   = 16,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [47:0]               cycle_number,
  input  logic [CHANNELS*WIDTH-1:0] real_data,
  input  logic [CHANNELS*WIDTH-1:0] inj_data,
  input  logic [CHANNELS-1:0]       channel_mask,
  output logic [CHANNELS-1:0]       mismatch_now,
  output logic [CHANNELS-1:0]       mismatch_sticky,
  output logic                      first_valid,
  output logic [47:0]               first_cycle,
  output logic [COUNT_WIDTH-1:0]    mismatch_count,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [47:0]               log_cycle,
  output logic [CHANNELS-1:0]       log_channels,
  output logic [WIDTH-1:0]          log_xor,
  output logic                      log_overflow
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam int PTR_W = LOG_DEPTH + 1;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    DIVERGED = 2'd1,
    FROZEN   = 2'd2
  } state_t;

  state_t state;

  logic [CHANNELS-1:0] hit;
  logic [WIDTH-1:0]    first_xor;
  logic                any_hit;
  logic                record;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LOG_DEPTH-1:0] wr_addr;
  logic [LOG_DEPTH-1:0] rd_addr;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  logic [47:0]          mem_cycle    [DEPTH];
  logic [CHANNELS-1:0]  mem_channels [DEPTH];
  logic [WIDTH-1:0]     mem_xor      [DEPTH];

  // Scan from the top down so the lowest-index mismatching channel's xor wins.
  always_comb begin
    hit       = '0;
    first_xor = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      hit[i] = enable & ~channel_mask[i] &
               (real_data[i*WIDTH +: WIDTH] != inj_data[i*WIDTH +: WIDTH]);
      if (hit[i]) begin
        first_xor = real_data[i*WIDTH +: WIDTH] ^ inj_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any_hit = |hit;
  assign record  = any_hit & ~clear & (state != FROZEN);

  assign wr_addr    = wr_ptr[LOG_DEPTH-1:0];
  assign rd_addr    = rd_ptr[LOG_DEPTH-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) && (wr_addr == rd_addr);
  assign pop        = ~fifo_empty & log_ready & ~clear;
  // A pop frees the slot the push lands in, so push+pop while full both proceed.
  assign push       = record & (~fifo_full | pop);
  assign drop       = record & fifo_full & ~pop;

  assign log_valid    = ~fifo_empty;
  assign log_cycle    = log_valid ? mem_cycle[rd_addr]    : '0;
  assign log_channels = log_valid ? mem_channels[rd_addr] : '0;
  assign log_xor      = log_valid ? mem_xor[rd_addr]      : '0;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_cycle[wr_addr]    <= cycle_number;
      mem_channels[wr_addr] <= hit;
      mem_xor[wr_addr]      <= first_xor;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ARMED;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mismatch_now    <= '0;
      mismatch_sticky <= '0;
      first_valid     <= 1'b0;
      first_cycle     <= '0;
      mismatch_count  <= '0;
      log_overflow    <= 1'b0;
    end else if (clear) begin
      state           <= ARMED;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mismatch_now    <= '0;
      mismatch_sticky <= '0;
      first_valid     <= 1'b0;
      first_cycle     <= '0;
      mismatch_count  <= '0;
      log_overflow    <= 1'b0;
    end else begin
      mismatch_now <= hit;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (drop) begin
        log_overflow <= 1'b1;
      end
      if (record) begin
        mismatch_sticky <= mismatch_sticky | hit;
        if (mismatch_count != '1) begin
          mismatch_count <= mismatch_count + COUNT_WIDTH'(1);
        end
        if (state == ARMED) begin
          first_valid <= 1'b1;
          first_cycle <= cycle_number;
          state       <= (STOP_ON_FIRST != 0) ? FROZEN : DIVERGED;
        end
      end
    end
  end

endmodule
